// File: rtl/uart_sched_pkg.sv
// Package: uart_sched_pkg
// Shared types and constants for the uart_mmio bus scheduler.
//   state_t          scheduler FSM states
//   DEF_ADDR_*       default uart_mmio register addresses
//   STAT_RX/TXBUSY   bit positions inside the status register
package uart_sched_pkg;

    typedef enum logic [1:0] {
        POLL,
        RXRD,
        WRITE,
        SETTLE
    } state_t;

    localparam logic [7:0] DEF_ADDR_DATA = 8'h80;
    localparam logic [7:0] DEF_ADDR_RX   = 8'h81;
    localparam logic [7:0] DEF_ADDR_STAT = 8'h82;

    localparam int STAT_RX     = 1;
    localparam int STAT_TXBUSY = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Module: rr_arbiter
// Combinational round-robin arbiter. The search starts at index ptr and
// wraps modulo N; the first requester that is both requesting and unmasked
// wins. The pointer register lives in the parent.
//   req           in   N    request vector
//   mask          in   N    eligibility mask (1 = may win)
//   ptr           in   IW   first index to examine
//   grant_onehot  out  N    one-hot winner (all zero when none)
//   grant_idx     out  IW   index of the winner (0 when none)
//   any           out  1    a winner exists
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [N-1:0] elig;

    // NOTE: every signal driven here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        elig         = req & mask;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && elig[j]) begin
                any             = 1'b1;
                grant_onehot[j] = 1'b1;
                grant_idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_bus_sched.sv
// Module: uart_bus_sched
// Sole master of the uart_mmio register port. Polls status continuously,
// drains received bytes to a broadcast rx output (RX beats TX), and pushes
// round-robin granted requester bytes into the TX data register.
// Optional feature: define UART_SCHED_LOCK_EN to lock the grant to one
// requester until it transfers a byte with req_last=1.
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/data/last/ready   NREQ byte-stream requesters (ready is a
//                   one-hot accept pulse, transfer on valid&ready)
//   rx_valid/rx_data            one-cycle pulse with a received byte
//   grant_id        index of the last accepted requester
//   bus_cs/we/addr/wdata/rdata  uart_mmio register port (rdata is
//                   combinational, sampled in the read cycle)
module uart_bus_sched
    import uart_sched_pkg::*;
#(
    parameter  int         NREQ       = 2,
    parameter  int         SETTLE_CYC = 2,
    parameter  logic [7:0] ADDR_DATA  = DEF_ADDR_DATA,
    parameter  logic [7:0] ADDR_RX    = DEF_ADDR_RX,
    parameter  logic [7:0] ADDR_STAT  = DEF_ADDR_STAT,
    localparam int         IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    output logic [IDW-1:0]    grant_id,
    output logic              bus_cs,
    output logic              bus_we,
    output logic [7:0]        bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t          state, state_nxt;
    logic [7:0]      hold;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   settle_cnt;
    logic            accept;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] win_onehot;
    logic [IDW-1:0]  win_idx;
    logic            win_any;

`ifdef UART_SCHED_LOCK_EN
    logic lock;

    // While locked only the current owner (last grantee) is eligible.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            mask[i] = !lock || (grant_id == IDW'(i));
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign mask        = '1;
`endif

    rr_arbiter #(.N(NREQ)) u_arb (
        .req          (req_valid),
        .mask         (mask),
        .ptr          (ptr),
        .grant_onehot (win_onehot),
        .grant_idx    (win_idx),
        .any          (win_any)
    );

    // Outputs are gated by rst_n so the bus is quiet while reset is held,
    // even though the state register already sits in POLL.
    always_comb begin
        state_nxt = state;
        bus_cs    = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        req_ready = '0;
        accept    = 1'b0;
        if (rst_n) begin
            case (state)
                POLL: begin
                    bus_cs   = 1'b1;
                    bus_addr = ADDR_STAT;
                    if (bus_rdata[STAT_RX]) begin
                        state_nxt = RXRD;
                    end else if (!bus_rdata[STAT_TXBUSY] && win_any) begin
                        req_ready = win_onehot;
                        accept    = 1'b1;
                        state_nxt = WRITE;
                    end
                end
                RXRD: begin
                    bus_cs    = 1'b1;
                    bus_addr  = ADDR_RX;
                    state_nxt = POLL;
                end
                WRITE: begin
                    bus_cs    = 1'b1;
                    bus_we    = 1'b1;
                    bus_addr  = ADDR_DATA;
                    bus_wdata = hold;
                    state_nxt = SETTLE;
                end
                SETTLE: begin
                    // Bus stays idle so a stale tx_busy=0 is never sampled.
                    if (settle_cnt == CW'(SETTLE_CYC - 1)) state_nxt = POLL;
                end
                default: state_nxt = POLL;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= POLL;
            hold       <= '0;
            ptr        <= '0;
            grant_id   <= '0;
            settle_cnt <= '0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
`ifdef UART_SCHED_LOCK_EN
            lock       <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            rx_valid <= (state == RXRD);
            if (state == RXRD) rx_data <= bus_rdata;
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            if (accept) begin
                hold     <= req_data[8*win_idx +: 8];
                grant_id <= win_idx;
                ptr      <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`ifdef UART_SCHED_LOCK_EN
                // Set on a non-final byte, cleared by the owner's final byte.
                lock     <= !req_last[win_idx];
`endif
            end
        end
    end

endmodule
